// File: rtl/single_cycle_cpu.sv
// single_cycle_cpu: RV32I base integer core, one instruction per clock.
// Illegal, misaligned or out-of-range instructions assert halt and freeze state.
module scc_mem #(
  parameter int WORDS = 1024
) (
  input  logic        clk,
  input  logic        we,
  input  logic [29:0] waddr,
  input  logic [3:0]  wbe,
  input  logic [31:0] wdata,
  input  logic [29:0] raddr,
  output logic [31:0] rdata
);
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [31:0] Mem [WORDS];
  logic        w_ok;
  logic        r_ok;

  assign w_ok  = {2'b00, waddr} < 32'(WORDS);
  assign r_ok  = {2'b00, raddr} < 32'(WORDS);
  assign rdata = r_ok ? Mem[raddr[AW-1:0]] : '0;

  // byte-lane write, only the enabled lanes change
  always_ff @(posedge clk) begin
    if (we && w_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) Mem[waddr[AW-1:0]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end
endmodule

module scc_rf (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] Mem [32];

  assign rd1 = (ra1 == 5'd0) ? '0 : Mem[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : Mem[ra2];

  // x0 pinned to zero by reset; other entries keep contents across reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) Mem[0] <= '0;
    else if (we && wa != 5'd0) Mem[wa] <= wd;
  end
endmodule

module single_cycle_cpu #(
  parameter int IMEM_WORDS = 1024,
  parameter int DMEM_WORDS = 1024
) (
  input  logic clk,
  input  logic rst,
  output logic halt
);
  logic [31:0] PC, pc_d, pc_4, InstWord;
  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_v, rs2_v, rd_val, mem_addr, dm_rdata;
  logic [31:0] st_data;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [3:0]  st_be;
  logic        rd_we, is_ld, is_st, tk;
  logic        bad_op, bad_al, im_oob, dm_oob;
  logic        eq, lt, ltu;

  assign opcode = InstWord[6:0];
  assign rd     = InstWord[11:7];
  assign f3     = InstWord[14:12];
  assign rs1    = InstWord[19:15];
  assign rs2    = InstWord[24:20];
  assign f7     = InstWord[31:25];

  assign imm_i = {{20{InstWord[31]}}, InstWord[31:20]};
  assign imm_s = {{20{InstWord[31]}}, InstWord[31:25], InstWord[11:7]};
  assign imm_b = {{19{InstWord[31]}}, InstWord[31], InstWord[7],
                  InstWord[30:25], InstWord[11:8], 1'b0};
  assign imm_u = {InstWord[31:12], 12'h000};
  assign imm_j = {{11{InstWord[31]}}, InstWord[31], InstWord[19:12],
                  InstWord[20], InstWord[30:21], 1'b0};

  assign pc_4     = PC + 32'd4;
  assign im_oob   = {2'b00, PC[31:2]} >= 32'(IMEM_WORDS);
  assign mem_addr = rs1_v + ((opcode == 7'b0100011) ? imm_s : imm_i);
  assign ld_b     = dm_rdata[{mem_addr[1:0], 3'b000} +: 8];
  assign ld_h     = mem_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
  assign eq       = rs1_v == rs2_v;
  assign lt       = $signed(rs1_v) < $signed(rs2_v);
  assign ltu      = rs1_v < rs2_v;
  assign halt     = bad_op | bad_al | im_oob | dm_oob;

  function automatic logic [31:0] alu(
    input logic [2:0]  f,
    input logic        alt,
    input logic [31:0] a,
    input logic [31:0] b
  );
    case (f)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return {31'b0, $signed(a) < $signed(b)};
      3'd3:    return {31'b0, a < b};
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  scc_mem #(.WORDS(IMEM_WORDS)) IMEM (
    .clk(clk), .we(1'b0), .waddr(30'd0), .wbe(4'd0), .wdata(32'd0),
    .raddr(PC[31:2]), .rdata(InstWord)
  );

  scc_mem #(.WORDS(DMEM_WORDS)) DMEM (
    .clk(clk), .we(is_st & ~halt & ~rst), .waddr(mem_addr[31:2]),
    .wbe(st_be), .wdata(st_data), .raddr(mem_addr[31:2]), .rdata(dm_rdata)
  );

  scc_rf RF (
    .clk(clk), .rst(rst), .we(rd_we & ~halt & ~rst), .wa(rd), .wd(rd_val),
    .ra1(rs1), .ra2(rs2), .rd1(rs1_v), .rd2(rs2_v)
  );

  // decode/execute: result, next PC and halt causes for the current word
  always_comb begin
    bad_op  = 1'b0;
    bad_al  = 1'b0;
    dm_oob  = 1'b0;
    rd_we   = 1'b0;
    rd_val  = '0;
    pc_d    = pc_4;
    is_ld   = 1'b0;
    is_st   = 1'b0;
    tk      = 1'b0;
    st_be   = '0;
    st_data = rs2_v << {mem_addr[1:0], 3'b000};
    case (opcode)
      7'b0110111: begin
        rd_we  = 1'b1;
        rd_val = imm_u;
      end
      7'b0010111: begin
        rd_we  = 1'b1;
        rd_val = PC + imm_u;
      end
      7'b1101111: begin
        rd_we  = 1'b1;
        rd_val = pc_4;
        pc_d   = PC + imm_j;
        bad_al = pc_d[1:0] != 2'b00;
      end
      7'b1100111: begin
        if (f3 != 3'd0) bad_op = 1'b1;
        rd_we  = 1'b1;
        rd_val = pc_4;
        pc_d   = (rs1_v + imm_i) & ~32'd1;
        bad_al = pc_d[1];
      end
      7'b1100011: begin
        case (f3)
          3'd0:    tk = eq;
          3'd1:    tk = ~eq;
          3'd4:    tk = lt;
          3'd5:    tk = ~lt;
          3'd6:    tk = ltu;
          3'd7:    tk = ~ltu;
          default: bad_op = 1'b1;
        endcase
        if (tk) begin
          pc_d   = PC + imm_b;
          bad_al = pc_d[1:0] != 2'b00;
        end
      end
      7'b0000011: begin
        is_ld = 1'b1;
        rd_we = 1'b1;
        case (f3)
          3'd0: rd_val = {{24{ld_b[7]}}, ld_b};
          3'd4: rd_val = {24'b0, ld_b};
          3'd1: begin
            rd_val = {{16{ld_h[15]}}, ld_h};
            bad_al = mem_addr[0];
          end
          3'd5: begin
            rd_val = {16'b0, ld_h};
            bad_al = mem_addr[0];
          end
          3'd2: begin
            rd_val = dm_rdata;
            bad_al = mem_addr[1:0] != 2'b00;
          end
          default: bad_op = 1'b1;
        endcase
      end
      7'b0100011: begin
        is_st = 1'b1;
        case (f3)
          3'd0: st_be = 4'b0001 << mem_addr[1:0];
          3'd1: begin
            st_be  = 4'b0011 << mem_addr[1:0];
            bad_al = mem_addr[0];
          end
          3'd2: begin
            st_be  = 4'b1111;
            bad_al = mem_addr[1:0] != 2'b00;
          end
          default: bad_op = 1'b1;
        endcase
      end
      7'b0010011: begin
        if (f3 == 3'd1 && f7 != 7'h00) bad_op = 1'b1;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) bad_op = 1'b1;
        rd_we  = 1'b1;
        rd_val = alu(f3, (f3 == 3'd5) & f7[5], rs1_v, imm_i);
      end
      7'b0110011: begin
        if (f7 != 7'h00 && f7 != 7'h20) bad_op = 1'b1;
        if (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) bad_op = 1'b1;
        rd_we  = 1'b1;
        rd_val = alu(f3, f7[5], rs1_v, rs2_v);
      end
      default: bad_op = 1'b1;
    endcase
    if (is_ld || is_st) dm_oob = {2'b00, mem_addr[31:2]} >= 32'(DMEM_WORDS);
  end

  // program counter: held at 0 in reset, frozen while halted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) PC <= '0;
    else if (!halt) PC <= pc_d;
  end
endmodule

// File: tb/tb_single_cycle_cpu.sv
// tb_single_cycle_cpu: directed RV32I programs with hand-computed results.
// Small memories so out-of-range accesses can be reached.
module tb_single_cycle_cpu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halt;
  int   checks = 0;
  int   failures = 0;

  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_L = 7'b0000011;

  single_cycle_cpu #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
    .clk(clk), .rst(rst), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7,
    input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_R};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm,
    input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd,
    input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm,
    input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm,
    input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm,
    input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic begin_prog();
    rst = 1'b1;
    for (int i = 0; i < 64; i++) dut.IMEM.Mem[i] = 32'h0;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    rst = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    begin_prog();
    #1;
    chk("rst_pc", dut.PC, 32'h0);
    chk("rst_halt_zero_word", {31'b0, halt}, 32'd1);

    // lui / auipc then an all-zero word
    dut.IMEM.Mem[0] = {20'h12345, 5'd1, 7'b0110111};
    dut.IMEM.Mem[1] = {20'h00001, 5'd2, 7'b0010111};
    #1;
    chk("rst_halt_lui", {31'b0, halt}, 32'd0);
    run(5);
    chk("lui_x1", dut.RF.Mem[1], 32'h12345000);
    chk("auipc_x2", dut.RF.Mem[2], 32'h00001004);
    chk("p1_pc", dut.PC, 32'd8);
    chk("p1_halt", {31'b0, halt}, 32'd1);

    // shifts, compares, sub, register shift amount
    begin_prog();
    dut.IMEM.Mem[0] = enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, OP_I);
    dut.IMEM.Mem[1] = enc_i(12'h01C, 5'd1, 3'd5, 5'd2, OP_I);
    dut.IMEM.Mem[2] = enc_i(12'h41C, 5'd1, 3'd5, 5'd3, OP_I);
    dut.IMEM.Mem[3] = enc_r(7'h00, 5'd1, 5'd0, 3'd3, 5'd4);
    dut.IMEM.Mem[4] = enc_i(12'd33, 5'd0, 3'd0, 5'd5, OP_I);
    dut.IMEM.Mem[5] = enc_r(7'h00, 5'd5, 5'd1, 3'd1, 5'd6);
    dut.IMEM.Mem[6] = enc_r(7'h20, 5'd1, 5'd0, 3'd0, 5'd7);
    dut.IMEM.Mem[7] = enc_r(7'h00, 5'd0, 5'd1, 3'd2, 5'd8);
    run(10);
    chk("addi_x1", dut.RF.Mem[1], 32'hFFFFFFFF);
    chk("srli_x2", dut.RF.Mem[2], 32'h0000000F);
    chk("srai_x3", dut.RF.Mem[3], 32'hFFFFFFFF);
    chk("sltu_x4", dut.RF.Mem[4], 32'd1);
    chk("sll_x6", dut.RF.Mem[6], 32'hFFFFFFFE);
    chk("sub_x7", dut.RF.Mem[7], 32'd1);
    chk("slt_x8", dut.RF.Mem[8], 32'd1);
    chk("p2_pc", dut.PC, 32'd32);

    // loads and stores by width
    begin_prog();
    dut.DMEM.Mem[0] = 32'h80FF7F01;
    dut.DMEM.Mem[1] = 32'h11223344;
    dut.IMEM.Mem[0] = enc_i(12'd1, 5'd0, 3'd0, 5'd1, OP_L);
    dut.IMEM.Mem[1] = enc_i(12'd1, 5'd0, 3'd4, 5'd2, OP_L);
    dut.IMEM.Mem[2] = enc_i(12'd2, 5'd0, 3'd1, 5'd3, OP_L);
    dut.IMEM.Mem[3] = enc_s(12'd0, 5'd1, 5'd0, 3'd0);
    dut.IMEM.Mem[4] = enc_s(12'd6, 5'd3, 5'd0, 3'd1);
    dut.IMEM.Mem[5] = enc_i(12'd4, 5'd0, 3'd2, 5'd9, OP_L);
    run(8);
    chk("lb_x1", dut.RF.Mem[1], 32'h0000007F);
    chk("lbu_x2", dut.RF.Mem[2], 32'h0000007F);
    chk("lh_x3", dut.RF.Mem[3], 32'hFFFF80FF);
    chk("sb_mem0", dut.DMEM.Mem[0], 32'h80FF7F7F);
    chk("sh_mem1", dut.DMEM.Mem[1], 32'h80FF3344);
    chk("lw_x9", dut.RF.Mem[9], 32'h80FF3344);

    // beq skip, jal, jalr back to a halting word
    begin_prog();
    dut.RF.Mem[5] = 32'h0;
    dut.IMEM.Mem[0] = enc_b(13'd8, 5'd0, 5'd0, 3'd0);
    dut.IMEM.Mem[1] = enc_i(12'd1, 5'd0, 3'd0, 5'd5, OP_I);
    dut.IMEM.Mem[2] = enc_j(21'd8, 5'd6);
    dut.IMEM.Mem[4] = enc_i(12'd0, 5'd6, 3'd0, 5'd0, 7'b1100111);
    run(6);
    chk("beq_skip_x5", dut.RF.Mem[5], 32'h0);
    chk("jal_x6", dut.RF.Mem[6], 32'd12);
    chk("jalr_pc", dut.PC, 32'd12);

    // unsigned vs signed branches, x0 write discarded
    begin_prog();
    dut.RF.Mem[2] = 32'h0;
    dut.RF.Mem[3] = 32'h0;
    dut.IMEM.Mem[0] = enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, OP_I);
    dut.IMEM.Mem[1] = enc_b(13'd8, 5'd1, 5'd0, 3'd6);
    dut.IMEM.Mem[2] = enc_i(12'd1, 5'd0, 3'd0, 5'd2, OP_I);
    dut.IMEM.Mem[3] = enc_b(13'd8, 5'd1, 5'd0, 3'd4);
    dut.IMEM.Mem[4] = enc_i(12'd3, 5'd0, 3'd0, 5'd3, OP_I);
    dut.IMEM.Mem[5] = enc_i(12'd5, 5'd0, 3'd0, 5'd0, OP_I);
    run(8);
    chk("bltu_skip_x2", dut.RF.Mem[2], 32'h0);
    chk("blt_fall_x3", dut.RF.Mem[3], 32'd3);
    chk("x0_zero", dut.RF.Mem[0], 32'h0);
    chk("p5_pc", dut.PC, 32'd24);

    // misaligned lw halts in place
    begin_prog();
    dut.RF.Mem[1] = 32'hDEADBEEF;
    dut.IMEM.Mem[0] = enc_i(12'd2, 5'd0, 3'd2, 5'd1, OP_L);
    #1;
    chk("lw_mis_halt_rst", {31'b0, halt}, 32'd1);
    run(3);
    chk("lw_mis_pc", dut.PC, 32'h0);
    chk("lw_mis_x1", dut.RF.Mem[1], 32'hDEADBEEF);
    chk("lw_mis_halt", {31'b0, halt}, 32'd1);

    // last DMEM word loads, one past it halts
    begin_prog();
    dut.RF.Mem[1] = 32'h00001111;
    dut.DMEM.Mem[63] = 32'hCAFEF00D;
    dut.IMEM.Mem[0] = enc_i(12'd252, 5'd0, 3'd2, 5'd2, OP_L);
    dut.IMEM.Mem[1] = enc_i(12'd256, 5'd0, 3'd2, 5'd1, OP_L);
    run(4);
    chk("lw_last_x2", dut.RF.Mem[2], 32'hCAFEF00D);
    chk("lw_oob_x1", dut.RF.Mem[1], 32'h00001111);
    chk("lw_oob_pc", dut.PC, 32'd4);

    // untaken misaligned branch is fine, taken one halts
    begin_prog();
    dut.IMEM.Mem[0] = enc_b(13'd6, 5'd0, 5'd0, 3'd1);
    dut.IMEM.Mem[1] = enc_b(13'd6, 5'd0, 5'd0, 3'd0);
    run(3);
    chk("br_mis_pc", dut.PC, 32'd4);
    chk("br_mis_halt", {31'b0, halt}, 32'd1);

    // asynchronous reset mid-program keeps register contents
    begin_prog();
    dut.IMEM.Mem[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1, OP_I);
    dut.IMEM.Mem[1] = enc_i(12'd6, 5'd0, 3'd0, 5'd2, OP_I);
    dut.IMEM.Mem[2] = enc_j(21'd0, 5'd0);
    run(4);
    chk("loop_pc", dut.PC, 32'd8);
    rst = 1'b1;
    #1;
    chk("async_rst_pc", dut.PC, 32'h0);
    chk("rst_keep_x1", dut.RF.Mem[1], 32'd5);
    chk("rst_keep_x2", dut.RF.Mem[2], 32'd6);
    @(negedge clk);
    run(1);
    chk("resume_pc", dut.PC, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/single_cycle_cpu.md
SINGLE_CYCLE_CPU -- requirements
Module: single_cycle_cpu

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 1024, meaning instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter DMEM_WORDS, default 1024, meaning data memory depth in 32-bit words.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port halt, output, 1 bit: the current instruction cannot be executed and the CPU is stopped.
REQ-006 SHALL expose hierarchical names for bench access:
- PC: 32-bit register.
- InstWord: 32-bit fetched instruction.
- IMEM.Mem, DMEM.Mem, RF.Mem: arrays of 32-bit words; RF.Mem has 32 entries.

Function
REQ-007 SHALL complete one RV32I instruction per clock: fetch InstWord = IMEM.Mem[PC[31:2]], decode, execute, memory, writeback, all in the same cycle.
REQ-008 SHALL support these instructions:
- LUI, AUIPC, JAL, JALR.
- BEQ, BNE, BLT, BGE, BLTU, BGEU.
- LB, LH, LW, LBU, LHU; SB, SH, SW.
- ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
- ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
REQ-009 SHALL sign-extend immediates per the RV32I I/S/B/U/J formats; U-type immediate = inst[31:12] shifted left by 12.
REQ-010 SHALL compute results as follows:
- LUI: rd = imm.
- AUIPC: rd = PC + imm.
- JAL: rd = PC+4, nextPC = PC + imm.
- JALR: rd = PC+4, nextPC = (rs1 + imm) & ~1.
REQ-011 SHALL set nextPC = PC + imm when a branch is taken, else PC+4; comparisons are signed or unsigned per the funct3 encoding.
REQ-012 SHALL use only the low 5 bits of the shift amount (shamt[4:0] or rs2[4:0]); SRA/SRAI shift arithmetically.
REQ-013 SHALL wrap all arithmetic modulo 2^32 with no overflow trap.
REQ-014 SHALL handle x0 as follows: reads return 0; writes to x0 are discarded; RF.Mem[0] stays 0.
REQ-015 SHALL write the register file synchronously and read it combinationally; an instruction reading the rd written by the previous instruction sees the new value.
REQ-016 SHALL address DMEM by byte address: word index = addr[31:2]; byte lane = addr[1:0].
REQ-017 SHALL handle loads and stores by width:
- Loads: sign- or zero-extend per funct3.
- Stores: update only the addressed bytes; stores are synchronous.
- Loads: combinational read.
REQ-018 SHALL assert halt combinationally when the current instruction meets any of these conditions:
- Opcode/funct unsupported, including ECALL, EBREAK, FENCE and all-zero or all-ones words.
- Jump or taken-branch target not 4-byte aligned.
- LH/LHU/SH address not 2-byte aligned.
- LW/SW address not 4-byte aligned.
- Word index out of range of IMEM_WORDS/DMEM_WORDS.
REQ-019 SHALL block all writes while halt is high: no PC, register-file or data-memory write; the CPU stays on the halting instruction indefinitely.
REQ-020 SHALL let PC wrap modulo 2^32; a fetch beyond IMEM_WORDS halts per REQ-018.

Reset
REQ-021 SHALL clear PC to 0x00000000 asynchronously when rst is high and hold it while rst remains high.
REQ-022 SHALL perform no writes to the register file or data memory while rst is high.
REQ-023 SHALL not clear RF.Mem (except entry 0), IMEM.Mem or DMEM.Mem on reset, so a bench can preload them before or after reset.
REQ-024 SHALL drive halt as a pure function of the instruction at PC 0 while in reset.
REQ-025 SHALL resume execution at PC 0 on the first rising edge after rst deasserts.

Verification
REQ-026 Program lui x1,0x12345; auipc x2,0x1; then 0x00000000 -> x1=0x12345000, x2=0x00001004; halt=1 at PC=8, PC holds at 8.
REQ-027 Program addi x1,x0,-1; srli x2,x1,28; srai x3,x1,28; sltu x4,x0,x1 -> x1=0xFFFFFFFF, x2=0x0000000F, x3=0xFFFFFFFF, x4=1.
REQ-028 Program with DMEM.Mem[0]=0x80FF7F01: lb x1,1(x0); lbu x2,1(x0); lh x3,2(x0); sb x1,0(x0) -> x1=0x0000007F, x2=0x0000007F, x3=0xFFFF80FF, DMEM.Mem[0]=0x80FF7F7F.
REQ-029 Program beq x0,x0,+8 skipping addi x5,x0,1; then jal x6,+8; jalr x0,0(x6) -> x5=0, x6=PC_of_jal+4, branch and jumps land correctly.
REQ-030 Program with lw x1,2(x0) -> halt=1 immediately; x1 is unchanged; PC is unchanged over 3 further clocks.
REQ-031 Assert rst mid-program -> PC=0 without waiting for a clock edge; RF contents written before the reset are retained.
